// File: rtl/pll_mgmt_if.sv
// Management port of the PLL reconfig block.
// Registered write channel from the sequencer plus the stall input.
interface pll_mgmt_if;
    logic        write;
    logic [5:0]  address;
    logic [31:0] writedata;
    logic        waitrequest;

    modport master (
        output write,
        output address,
        output writedata,
        input  waitrequest
    );

    modport slave (
        input  write,
        input  address,
        input  writedata,
        output waitrequest
    );
endinterface

// File: rtl/pll_speed_ctrl.sv
// Game-speed PLL reconfiguration sequencer.
// Writes mode, K and start registers, then waits for relock with timeout.
module pll_speed_ctrl #(
    parameter logic [31:0] K_NATIVE     = 32'd2748778984,
    parameter logic [31:0] K_FAST       = 32'd3221912667,
    parameter int unsigned SETTLE       = 16,
    parameter logic [19:0] LOCK_TIMEOUT = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        speed_sel,
    input  logic        pll_locked,
    pll_mgmt_if.master  mgmt,
    output logic        core_hold,
    output logic        busy,
    output logic        error
);
    localparam logic [19:0] SETTLE_W = 20'(SETTLE);
    localparam logic [19:0] CNT_MAX  = 20'hFFFFF;

    typedef enum logic [2:0] {
        IDLE, MODE, GAP1, KWR, GAP2, START, WAIT_LOCK, DONE
    } state_t;

    state_t      state, state_n;
    logic [1:0]  sel_ff;
    logic        s_prev;
    logic [2:0]  primed;
    logic [1:0]  lock_ff;
    logic        applied, force_wr, target;
    logic [19:0] cnt;
    logic        write_n, busy_n, error_n;
    logic [5:0]  addr_n;
    logic [31:0] data_n;
    logic        go, start_ok, accept, stable;

    // primed keeps the request unstable until the synchroniser has refilled
    assign stable = primed[2] && (sel_ff[1] == s_prev);
    assign accept = mgmt.write && !mgmt.waitrequest;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            sel_ff         <= '0;
            s_prev         <= 1'b0;
            primed         <= '0;
            lock_ff        <= '0;
            applied        <= 1'b0;
            force_wr       <= 1'b1;
            target         <= 1'b0;
            cnt            <= '0;
            mgmt.write     <= 1'b0;
            mgmt.address   <= '0;
            mgmt.writedata <= '0;
            busy           <= 1'b0;
            core_hold      <= 1'b0;
            error          <= 1'b0;
        end else begin
            state          <= state_n;
            sel_ff         <= {sel_ff[0], speed_sel};
            s_prev         <= sel_ff[1];
            primed         <= {primed[1:0], 1'b1};
            lock_ff        <= {lock_ff[0], pll_locked};
            mgmt.write     <= write_n;
            mgmt.address   <= addr_n;
            mgmt.writedata <= data_n;
            busy           <= busy_n;
            core_hold      <= busy_n;
            error          <= error_n;
            if (go)
                target <= sel_ff[1];
            if (start_ok) begin
                applied  <= target;
                force_wr <= 1'b0;
            end
            if (state != WAIT_LOCK)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 20'd1;
        end
    end

    always_comb begin
        state_n  = state;
        write_n  = mgmt.write;
        addr_n   = mgmt.address;
        data_n   = mgmt.writedata;
        error_n  = error;
        go       = 1'b0;
        start_ok = 1'b0;
        unique case (state)
            IDLE: begin
                if (stable && ((sel_ff[1] != applied) || force_wr)) begin
                    go      = 1'b1;
                    state_n = MODE;
                    write_n = 1'b1;
                    addr_n  = 6'd0;
                    data_n  = 32'd0;
                end
            end
            MODE: begin
                if (accept) begin
                    state_n = GAP1;
                    write_n = 1'b0;
                end
            end
            GAP1: begin
                state_n = KWR;
                write_n = 1'b1;
                addr_n  = 6'd7;
                data_n  = target ? K_FAST : K_NATIVE;
            end
            KWR: begin
                if (accept) begin
                    state_n = GAP2;
                    write_n = 1'b0;
                end
            end
            GAP2: begin
                state_n = START;
                write_n = 1'b1;
                addr_n  = 6'd2;
                data_n  = 32'd0;
            end
            START: begin
                if (accept) begin
                    start_ok = 1'b1;
                    state_n  = WAIT_LOCK;
                    write_n  = 1'b0;
                end
            end
            WAIT_LOCK: begin
                // lock is checked first so it wins over a same-cycle timeout
                if (cnt >= SETTLE_W && lock_ff[1]) begin
                    state_n = DONE;
                    error_n = 1'b0;
                end else if (cnt == LOCK_TIMEOUT) begin
                    state_n = DONE;
                    error_n = 1'b1;
                end
            end
            DONE: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end
endmodule

// File: tb/tb_pll_speed_ctrl.sv
// Scoreboard bench for pll_speed_ctrl: expected writes are queued by the
// stimulus and popped by a negedge monitor on each accepted write.
module tb_pll_speed_ctrl;
    localparam logic [31:0] KN = 32'd2748778984;
    localparam logic [31:0] KF = 32'd3221912667;

    logic clk = 1'b0;
    logic reset;
    logic speed_sel;
    logic pll_locked;
    logic core_hold, busy, error;
    pll_mgmt_if mgmt();

    int checks = 0;
    int errors = 0;
    logic [37:0] exp_q[$];

    pll_speed_ctrl #(
        .K_NATIVE(KN),
        .K_FAST(KF),
        .SETTLE(16),
        .LOCK_TIMEOUT(20'd100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .speed_sel(speed_sel),
        .pll_locked(pll_locked),
        .mgmt(mgmt),
        .core_hold(core_hold),
        .busy(busy),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] k);
        exp_q.push_back({6'd0, 32'd0});
        exp_q.push_back({6'd7, k});
        exp_q.push_back({6'd2, 32'd0});
    endtask

    // monitor: every accepted write must match the head of the queue
    always @(negedge clk) begin
        if (!reset && mgmt.write && !mgmt.waitrequest) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %0d",
                         mgmt.address, mgmt.writedata);
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mgmt.address), 32'(e[37:32]));
                chk("wr_data", mgmt.writedata, e[31:0]);
            end
        end
    end

    task automatic wait_done(input int budget, output int len);
        int n;
        n = 0;
        len = 0;
        while (!busy && n < budget) begin
            @(posedge clk); #1; n++;
        end
        if (busy) begin
            len = 1;
            while (busy && n < budget) begin
                @(posedge clk); #1; n++;
                if (busy) len++;
            end
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_done timeout: got %0d cycles limit %0d",
                     n, budget);
        end
    endtask

    task automatic wait_kwr(input int budget);
        int n;
        n = 0;
        while (!(mgmt.write && mgmt.address == 6'd7) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        chk("reach_kwr", 32'(n < budget), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_write"}, 32'(mgmt.write), 32'd0);
        chk({tag, "_addr"}, 32'(mgmt.address), 32'd0);
        chk({tag, "_data"}, mgmt.writedata, 32'd0);
        chk({tag, "_hold"}, 32'(core_hold), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        int len;
        int n;
        reset = 1'b1;
        speed_sel = 1'b0;
        pll_locked = 1'b1;
        mgmt.waitrequest = 1'b0;

        // power-up forced native sequence
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");
        push_seq(KN);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pwr_hold_e3", 32'(core_hold), 32'd0);
        @(posedge clk); #1;
        chk("pwr_hold_e4", 32'(core_hold), 32'd1);
        chk("pwr_write_e4", 32'(mgmt.write), 32'd1);
        wait_done(400, len);
        chk("pwr_busy_len", 32'(len), 32'd23);
        chk("pwr_hold_after", 32'(core_hold), 32'd0);
        chk("pwr_q_empty", 32'(exp_q.size()), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("idle_stays", 32'(busy), 32'd0);

        // switch to fast: MODE write after the fourth edge
        speed_sel = 1'b1;
        push_seq(KF);
        repeat (3) @(posedge clk);
        #1;
        chk("fast_write_e2", 32'(mgmt.write), 32'd0);
        @(posedge clk); #1;
        chk("fast_write_e3", 32'(mgmt.write), 32'd1);
        wait_done(400, len);
        chk("fast_q_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("fast_no_rerun", 32'(busy), 32'd0);

        // waitrequest stall across the K write
        speed_sel = 1'b0;
        push_seq(KN);
        n = 0;
        while (!(mgmt.write && mgmt.address == 6'd0) && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("stall_mode_seen", 32'(n < 40), 32'd1);
        @(posedge clk); #1;
        mgmt.waitrequest = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            chk("stall_write", 32'(mgmt.write), 32'd1);
            chk("stall_addr", 32'(mgmt.address), 32'd7);
            chk("stall_data", mgmt.writedata, KN);
        end
        mgmt.waitrequest = 1'b0;
        @(posedge clk); #1;
        chk("stall_gap", 32'(mgmt.write), 32'd0);
        @(posedge clk); #1;
        chk("stall_start_addr", 32'(mgmt.address), 32'd2);
        wait_done(400, len);
        chk("stall_q_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // toggle mid-sequence: fast finishes, native follows
        speed_sel = 1'b1;
        push_seq(KF);
        push_seq(KN);
        wait_kwr(40);
        speed_sel = 1'b0;
        wait_done(400, len);
        wait_done(400, len);
        chk("toggle_q_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // relock timeout, then recovery clears error
        pll_locked = 1'b0;
        speed_sel = 1'b1;
        push_seq(KF);
        wait_done(400, len);
        chk("to_busy_len", 32'(len), 32'd107);
        chk("to_error", 32'(error), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        pll_locked = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("to_error_sticky", 32'(error), 32'd1);
        speed_sel = 1'b0;
        push_seq(KN);
        wait_done(400, len);
        chk("rec_error", 32'(error), 32'd0);
        chk("rec_q_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // async reset in GAP2 forces a full rewrite
        speed_sel = 1'b1;
        exp_q.push_back({6'd0, 32'd0});
        exp_q.push_back({6'd7, KF});
        wait_kwr(40);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check_zero("async_rst");
        chk("gap2_q_empty", 32'(exp_q.size()), 32'd0);
        push_seq(KF);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_done(400, len);
        chk("rst_rerun_q_empty", 32'(exp_q.size()), 32'd0);
        chk("rst_rerun_error", 32'(error), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end
endmodule
